// File: rtl/alarm_trigger.sv
// alarm_trigger: free-running MM:SS BCD clock with a single latched alarm.
// Rings when the running time reaches the latched target; ringing ends on
// dismiss, on a fixed tick timeout, or (with ALARM_SNOOZE_EN defined) on
// snooze, which re-arms the alarm SNOOZE_MIN minutes after the current time.
//
// Handshake: alarm_valid is a level, not a valid/ready pair. While it is high
// the alarm value is final; the block samples it once on leaving IDLE and
// ignores further changes. Dropping alarm_valid forces IDLE on the next edge,
// overriding every other transition.
//
// o_state exposes the FSM state for observation (IDLE=0, ARMED=1,
// RINGING=2, DONE=3, SNOOZED=4).
module alarm_trigger #(
    parameter int unsigned RING_SECONDS = 30,
    parameter int unsigned SNOOZE_MIN   = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        tick,
    input  logic        alarm_valid,
    input  logic [15:0] alarm,
    input  logic        push_c,
    input  logic        push_d,
    output logic [15:0] time_bcd,
    output logic        armed,
    output logic        ringing,
    output logic        ring_led,
    output logic [2:0]  o_state
);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RINGING = 3'd2,
        ST_DONE    = 3'd3,
        ST_SNOOZED = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_RINGING = 3'd2,
        ST_DONE    = 3'd3
    } state_t;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_time;
    logic [15:0] r_target;
    logic [7:0]  r_ring_cnt;
    logic        r_armed;
    logic        r_ringing;
    logic        r_ring_led;

    logic [15:0] w_time_inc;
    logic        w_load_tgt;
    logic        w_snooze;
    logic        w_inc_cnt;
    logic        w_next_armed;

    // One-second BCD increment with per-digit carry, 59:59 wraps to 00:00.
    function automatic logic [15:0] bcd_inc(input logic [15:0] t);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = t;
        if (s1 == 4'd9) begin
            s1 = 4'd0;
            if (s10 == 4'd5) begin
                s10 = 4'd0;
                if (m1 == 4'd9) begin
                    m1  = 4'd0;
                    m10 = (m10 == 4'd5) ? 4'd0 : m10 + 4'd1;
                end else begin
                    m1 = m1 + 4'd1;
                end
            end else begin
                s10 = s10 + 4'd1;
            end
        end else begin
            s1 = s1 + 4'd1;
        end
        return {m10, m1, s10, s1};
    endfunction

`ifdef ALARM_SNOOZE_EN
    // Add SNOOZE_MIN minutes in BCD; seconds untouched, tens-of-minutes wrap 5->0.
    function automatic logic [15:0] bcd_add_min(input logic [15:0] t);
        logic [4:0] sum;
        logic [3:0] m1, m10;
        sum = {1'b0, t[11:8]} + 5'(SNOOZE_MIN);
        if (sum >= 5'd10) begin
            m1  = 4'(sum - 5'd10);
            m10 = (t[15:12] == 4'd5) ? 4'd0 : t[15:12] + 4'd1;
        end else begin
            m1  = sum[3:0];
            m10 = t[15:12];
        end
        return {m10, m1, t[7:0]};
    endfunction
`else
    // Snooze input is present on the port but has no function in this build.
    logic w_unused_push_d;
    assign w_unused_push_d = push_d;
`endif

    // Next-state decode and per-cycle control strobes.
    always_comb begin
        w_next       = r_state;
        w_time_inc   = bcd_inc(r_time);
        w_load_tgt   = 1'b0;
        w_snooze     = 1'b0;
        w_inc_cnt    = 1'b0;
        if (!alarm_valid) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_next     = ST_ARMED;
                    w_load_tgt = 1'b1;
                end
                ST_ARMED: begin
                    if (tick && (w_time_inc == r_target)) w_next = ST_RINGING;
                end
                ST_RINGING: begin
                    if (push_c) begin
                        w_next = ST_DONE;
`ifdef ALARM_SNOOZE_EN
                    end else if (push_d) begin
                        w_next   = ST_SNOOZED;
                        w_snooze = 1'b1;
`endif
                    end else if (tick) begin
                        if (r_ring_cnt == 8'(RING_SECONDS - 1)) w_next = ST_DONE;
                        else                                     w_inc_cnt = 1'b1;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZED: begin
                    if (tick && (w_time_inc == r_target)) w_next = ST_RINGING;
                end
`endif
                ST_DONE: begin
                    w_next = ST_DONE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
`ifdef ALARM_SNOOZE_EN
        w_next_armed = (w_next == ST_ARMED) || (w_next == ST_SNOOZED);
`else
        w_next_armed = (w_next == ST_ARMED);
`endif
    end

    // State register, time count, target latch, ring counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_time     <= 16'h0000;
            r_target   <= 16'h0000;
            r_ring_cnt <= 8'd0;
            r_armed    <= 1'b0;
            r_ringing  <= 1'b0;
            r_ring_led <= 1'b0;
        end else begin
            r_state <= w_next;
            if (tick) r_time <= w_time_inc;
            if (w_load_tgt) r_target <= alarm;
`ifdef ALARM_SNOOZE_EN
            if (w_snooze) r_target <= bcd_add_min(r_time);
`endif
            if ((w_next == ST_RINGING) && (r_state != ST_RINGING)) r_ring_cnt <= 8'd0;
            else if (w_inc_cnt)                                    r_ring_cnt <= r_ring_cnt + 8'd1;
            r_armed    <= w_next_armed;
            r_ringing  <= (w_next == ST_RINGING);
            r_ring_led <= ((w_next == ST_RINGING) && (r_state == ST_RINGING))
                          ? (r_ring_led ^ w_inc_cnt) : 1'b0;
        end
    end

    assign time_bcd = r_time;
    assign armed    = r_armed;
    assign ringing  = r_ringing;
    assign ring_led = r_ring_led;
    assign o_state  = r_state;

endmodule

// File: tb/tb_alarm_trigger.sv
// tb_alarm_trigger: directed plus randomized stimulus for alarm_trigger,
// checked every cycle against a seconds-based reference model.
module tb_alarm_trigger;
  localparam int RS = 3;
  localparam int SN = 5;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ = 1'b1;
`else
  localparam bit SNZ = 1'b0;
`endif
  localparam int M_IDLE = 0, M_ARMED = 1, M_RING = 2, M_DONE = 3, M_SNOOZED = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        tick = 1'b0;
  logic        alarm_valid = 1'b0;
  logic [15:0] alarm = 16'h0000;
  logic        push_c = 1'b0;
  logic        push_d = 1'b0;
  logic [15:0] time_bcd;
  logic        armed, ringing, ring_led;
  logic [2:0]  o_state;

  int checks = 0;
  int errors = 0;

  // reference model: time and target kept as plain seconds 0..3599
  int m_sec, m_tgt, m_mode, m_rcnt;
  bit m_led;

  alarm_trigger #(.RING_SECONDS(RS), .SNOOZE_MIN(SN)) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .alarm_valid(alarm_valid),
    .alarm(alarm), .push_c(push_c), .push_d(push_d), .time_bcd(time_bcd),
    .armed(armed), .ringing(ringing), .ring_led(ring_led), .o_state(o_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] sec2bcd(input int s);
    int m, ss;
    m  = s / 60;
    ss = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int bcd2sec(input logic [15:0] b);
    return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // advance the model by one clock using the inputs applied this cycle
  task automatic model_step(input bit rst, input bit tk, input bit av, input bit pc,
                            input bit pd, input logic [15:0] al);
    int nsec;
    if (rst) begin
      m_sec = 0; m_tgt = 0; m_mode = M_IDLE; m_rcnt = 0; m_led = 1'b0;
      return;
    end
    nsec = tk ? (m_sec + 1) % 3600 : m_sec;
    if (!av) begin
      m_mode = M_IDLE;
      m_led  = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: begin
          m_mode = M_ARMED;
          m_tgt  = bcd2sec(al);
        end
        M_ARMED, M_SNOOZED: begin
          if (tk && nsec == m_tgt) begin
            m_mode = M_RING; m_rcnt = 0; m_led = 1'b0;
          end
        end
        M_RING: begin
          if (pc) begin
            m_mode = M_DONE; m_led = 1'b0;
          end else if (pd && SNZ) begin
            m_mode = M_SNOOZED; m_led = 1'b0;
            m_tgt  = (m_sec + SN * 60) % 3600;
          end else if (tk) begin
            if (m_rcnt == RS - 1) begin
              m_mode = M_DONE; m_led = 1'b0;
            end else begin
              m_rcnt++; m_led = ~m_led;
            end
          end
        end
        default: ;
      endcase
    end
    m_sec = nsec;
  endtask

  // driver: apply one cycle of inputs, then compare all outputs after the edge
  task automatic step(input bit rst, input bit tk, input bit av, input bit pc,
                      input bit pd, input logic [15:0] al);
    resetn = ~rst; tick = tk; alarm_valid = av; push_c = pc; push_d = pd; alarm = al;
    model_step(rst, tk, av, pc, pd, al);
    @(posedge clk);
    #1;
    chk("time_bcd", time_bcd, sec2bcd(m_sec));
    chk("armed", {15'd0, armed}, {15'd0, (m_mode == M_ARMED || m_mode == M_SNOOZED)});
    chk("ringing", {15'd0, ringing}, {15'd0, (m_mode == M_RING)});
    chk("ring_led", {15'd0, ring_led}, {15'd0, m_led});
    chk("state", {13'd0, o_state}, 16'(m_mode));
  endtask

  task automatic ticks(input int n, input bit av, input logic [15:0] al);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, av, 1'b0, 1'b0, al);
  endtask

  initial begin
    // reset
    step(1, 0, 0, 0, 0, 16'h0000);
    step(1, 1, 1, 0, 0, 16'h1234);
    // count and wrap across a full hour with no alarm
    ticks(3600, 0, 16'h0000);
    chk("wrap_end", time_bcd, 16'h0000);
    // match at 00:12, then led toggling
    step(0, 0, 1, 0, 0, 16'h0012);
    ticks(11, 1, 16'h0012);
    step(0, 1, 1, 0, 0, 16'h0059);
    chk("match_ring", {15'd0, ringing}, 16'd1);
    chk("match_time", time_bcd, 16'h0012);
    ticks(1, 1, 16'h0059);
    // dismiss with simultaneous tick, then drop alarm_valid
    step(0, 1, 1, 1, 0, 16'h0012);
    chk("dismiss_time", time_bcd, 16'h0014);
    step(0, 0, 1, 0, 0, 16'h0012);
    step(0, 0, 0, 0, 0, 16'h0012);
    // timeout: ring at 00:05, falls on the tick producing 00:08
    step(1, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 16'h0005);
    ticks(8, 1, 16'h0005);
    chk("timeout_time", time_bcd, 16'h0008);
    ticks(3, 1, 16'h0005);
    // snooze across the hour: ring at 57:30, snooze at 57:31
    step(1, 0, 0, 0, 0, 16'h0000);
    ticks(3449, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 16'h5730);
    ticks(2, 1, 16'h5730);
    step(0, 0, 1, 0, 1, 16'h5730);
    ticks(301, 1, 16'h5730);
    step(0, 0, 0, 0, 0, 16'h0000);
    // priority: push_c and push_d together dismiss
    step(0, 0, 1, 0, 0, sec2bcd((m_sec + 2) % 3600));
    ticks(2, 1, 16'h0000);
    step(0, 0, 1, 1, 1, 16'h0000);
    step(0, 1, 1, 0, 0, 16'h0000);
    // reset mid-ring
    step(0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 1, 0, 0, sec2bcd((m_sec + 1) % 3600));
    ticks(2, 1, 16'h0000);
    step(1, 1, 1, 0, 0, 16'h0000);
    chk("reset_time", time_bcd, 16'h0000);
    // randomized phase
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 39) != 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 9) == 0, sec2bcd((m_sec + $urandom_range(1, 15)) % 3600));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
